axi4lite_reg_bank: RTL and testbench

Register and readout bank on the memory side of the AXI4-Lite slave interface, driven by its axi_mem_* port set. It holds the ID, control, interrupt and general-purpose configuration registers for a Caribou chip block. It also provides a small data FIFO that fabric logic fills and software drains by reading one address.

---
 rtl/axi4lite_reg_bank.sv | 164 ++++++++++++++++
 tb/tb_axi4lite_reg_bank.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_reg_bank.sv
// Caribou register bank on the axi_mem_* side of the AXI4-Lite slave: ID, CTRL, IRQ and RW registers.
// The readout FIFO and its status/data words exist only when REG_BANK_FIFO_EN is defined.
module axi4lite_reg_bank #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 11,
    parameter int          NUM_RW_REGS        = 8,
    parameter int          FIFO_DEPTH         = 16,
    parameter logic [31:0] ID_VALUE           = 32'hCA0B_0001,
    localparam int         DW                 = C_S_AXI_DATA_WIDTH,
    localparam int         WA                 = C_S_AXI_ADDR_WIDTH - ($clog2(C_S_AXI_DATA_WIDTH) - 3)
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESET,
    input  logic [WA-1:0]             axi_mem_wrAddr,
    input  logic [DW-1:0]             axi_mem_wdata,
    input  logic [DW/8-1:0]           axi_mem_wrByteStrobe,
    input  logic [WA-1:0]             axi_mem_rdAddr,
    input  logic                      axi_mem_rdStrobe,
    output logic [DW-1:0]             axi_mem_rdata,
    input  logic                      fifo_wr_valid,
    input  logic [DW-1:0]             fifo_wr_data,
    input  logic                      irq_event_i,
    output logic [NUM_RW_REGS*DW-1:0] rw_regs_o,
    output logic                      sw_reset_o,
    output logic                      irq_o
);
    localparam logic [WA-1:0] A_ID    = WA'(0);
    localparam logic [WA-1:0] A_CTRL  = WA'(1);
    localparam logic [WA-1:0] A_STAT  = WA'(2);
    localparam logic [WA-1:0] A_EN    = WA'(3);
    localparam logic [WA-1:0] A_FSTAT = WA'(4);
    localparam logic [WA-1:0] A_FDATA = WA'(5);
    localparam int            RW_BASE = 16;

    logic          wr_en_s, ctrl_wr_s, stat_wr_s, en_wr_s, sw_reset_req_s;
    logic [DW-1:0] strb_mask_s, rdata_s, fifo_status_s, fifo_head_s;
    logic [2:0]    irq_clr_s, irq_set_s, irq_status_r, irq_en_r;
    logic          irq_r, sw_reset_r, fifo_ovf_s, fifo_udf_s;
    logic [DW-1:0] rw_regs_r [NUM_RW_REGS];

    // Write decode and per-bit byte-lane mask
    always_comb begin
        wr_en_s = |axi_mem_wrByteStrobe;
        for (int b = 0; b < DW/8; b++) begin
            strb_mask_s[b*8 +: 8] = {8{axi_mem_wrByteStrobe[b]}};
        end
        ctrl_wr_s      = wr_en_s && (axi_mem_wrAddr == A_CTRL);
        stat_wr_s      = wr_en_s && (axi_mem_wrAddr == A_STAT);
        en_wr_s        = wr_en_s && (axi_mem_wrAddr == A_EN);
        sw_reset_req_s = ctrl_wr_s && axi_mem_wrByteStrobe[0] && axi_mem_wdata[0];
        irq_clr_s      = stat_wr_s ? (axi_mem_wdata[2:0] & strb_mask_s[2:0]) : 3'b000;
        irq_set_s      = {fifo_udf_s, irq_event_i, fifo_ovf_s};
    end

    // Control, interrupt and general-purpose register state
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                rw_regs_r[i] <= '0;
            end
            irq_status_r <= 3'b000;
            irq_en_r     <= 3'b000;
            irq_r        <= 1'b0;
            sw_reset_r   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                if (wr_en_s && (axi_mem_wrAddr == WA'(RW_BASE + i))) begin
                    rw_regs_r[i] <= (rw_regs_r[i] & ~strb_mask_s) | (axi_mem_wdata & strb_mask_s);
                end
            end
            if (en_wr_s) begin
                irq_en_r <= (irq_en_r & ~strb_mask_s[2:0]) | (axi_mem_wdata[2:0] & strb_mask_s[2:0]);
            end
            // Hardware set is OR-ed in after the clear so it wins a same-cycle collision
            irq_status_r <= (irq_status_r & ~irq_clr_s) | irq_set_s;
            irq_r        <= |(irq_status_r & irq_en_r);
            sw_reset_r   <= sw_reset_req_s;
        end
    end

`ifdef REG_BANK_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [DW-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          empty_s, full_s, flush_s, pop_s, push_s, rd_fifo_s;

    // FIFO handshake: flush beats push/pop, a pop frees room for a push when full
    always_comb begin
        empty_s    = (level_r == '0);
        full_s     = (level_r == LW'(FIFO_DEPTH));
        flush_s    = ctrl_wr_s && axi_mem_wrByteStrobe[0] && axi_mem_wdata[1];
        rd_fifo_s  = axi_mem_rdStrobe && (axi_mem_rdAddr == A_FDATA);
        pop_s      = rd_fifo_s && !empty_s && !flush_s;
        push_s     = fifo_wr_valid && (!full_s || pop_s) && !flush_s;
        fifo_ovf_s = fifo_wr_valid && full_s && !pop_s && !flush_s;
        fifo_udf_s = rd_fifo_s && empty_s;
        fifo_status_s       = '0;
        fifo_status_s[15:0] = 16'(level_r);
        fifo_status_s[16]   = empty_s;
        fifo_status_s[17]   = full_s;
        fifo_head_s         = empty_s ? '0 : fifo_mem_r[rd_ptr_r];
    end

    // FIFO storage, pointers and level
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (flush_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= fifo_wr_data;
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            level_r <= level_r + LW'(push_s) - LW'(pop_s);
        end
    end
`else
    logic unused_fifo_s;

    assign fifo_ovf_s    = 1'b0;
    assign fifo_udf_s    = 1'b0;
    assign fifo_status_s = '0;
    assign fifo_head_s   = '0;
    assign unused_fifo_s = ^{fifo_wr_valid, fifo_wr_data, axi_mem_rdStrobe, (FIFO_DEPTH > 1)};
`endif

    // Zero-latency read mux
    always_comb begin
        rdata_s = '0;
        case (axi_mem_rdAddr)
            A_ID:    rdata_s = DW'(ID_VALUE);
            A_STAT:  rdata_s[2:0] = irq_status_r;
            A_EN:    rdata_s[2:0] = irq_en_r;
            A_FSTAT: rdata_s = fifo_status_s;
            A_FDATA: rdata_s = fifo_head_s;
            default: rdata_s = '0;
        endcase
        for (int i = 0; i < NUM_RW_REGS; i++) begin
            rdata_s = (axi_mem_rdAddr == WA'(RW_BASE + i)) ? rw_regs_r[i] : rdata_s;
        end
    end

    for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_rw_out
        assign rw_regs_o[g*DW +: DW] = rw_regs_r[g];
    end

    assign axi_mem_rdata = rdata_s;
    assign sw_reset_o    = sw_reset_r;
    assign irq_o         = irq_r;
endmodule

// File: tb/tb_axi4lite_reg_bank.sv
// Self-checking bench for axi4lite_reg_bank against a queue/array reference model.
// Expectations follow REG_BANK_FIFO_EN so the same bench covers both builds.
module tb_axi4lite_reg_bank;
    localparam int          NRW   = 8;
    localparam int          DEPTH = 16;
    localparam logic [31:0] ID    = 32'hCA0B_0001;
`ifdef REG_BANK_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [8:0]     wr_addr, rd_addr;
    logic [31:0]    wdata, fifo_d, rdata;
    logic [3:0]     wstrb;
    logic           rd_strobe, fifo_v, irq_ev, sw_reset, irq;
    logic [NRW*32-1:0] rw_regs;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_rw [NRW];
    logic [2:0]  m_en, m_stat;
    logic        m_irq, m_swr;
    logic [31:0] m_q [$];

    axi4lite_reg_bank dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .axi_mem_wrAddr(wr_addr), .axi_mem_wdata(wdata), .axi_mem_wrByteStrobe(wstrb),
        .axi_mem_rdAddr(rd_addr), .axi_mem_rdStrobe(rd_strobe), .axi_mem_rdata(rdata),
        .fifo_wr_valid(fifo_v), .fifo_wr_data(fifo_d), .irq_event_i(irq_ev),
        .rw_regs_o(rw_regs), .sw_reset_o(sw_reset), .irq_o(irq)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < NRW; i++) m_rw[i] = 32'h0;
        m_en = 3'b0; m_stat = 3'b0; m_irq = 1'b0; m_swr = 1'b0;
        m_q.delete();
    endfunction

    // Next state of the register bank given the inputs currently applied
    function automatic void model_step();
        logic [31:0] mask;
        logic        wr, flush, do_pop;
        logic [2:0]  set_b, clr_b;
        int          sz;
        for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{wstrb[b]}};
        wr    = (wstrb != 4'b0);
        flush = FIFO_EN && wr && (wr_addr == 9'd1) && wstrb[0] && wdata[1];
        set_b = {1'b0, irq_ev, 1'b0};
        sz    = m_q.size();
        if (FIFO_EN) begin
            set_b[2] = rd_strobe && (rd_addr == 9'd5) && (sz == 0);
            if (flush) m_q.delete();
            else begin
                do_pop = rd_strobe && (rd_addr == 9'd5) && (sz > 0);
                if (do_pop) void'(m_q.pop_front());
                if (fifo_v) begin
                    if (sz < DEPTH || do_pop) m_q.push_back(fifo_d);
                    else set_b[0] = 1'b1;
                end
            end
        end
        clr_b  = (wr && wr_addr == 9'd2) ? (wdata[2:0] & mask[2:0]) : 3'b0;
        m_irq  = |(m_stat & m_en);
        m_stat = (m_stat & ~clr_b) | set_b;
        if (wr && wr_addr == 9'd3) m_en = (m_en & ~mask[2:0]) | (wdata[2:0] & mask[2:0]);
        for (int i = 0; i < NRW; i++)
            if (wr && wr_addr == 9'(16 + i)) m_rw[i] = (m_rw[i] & ~mask) | (wdata & mask);
        m_swr = wr && (wr_addr == 9'd1) && wstrb[0] && wdata[0];
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [8:0] a);
        int sz;
        sz = m_q.size();
        if (a == 9'd0) return ID;
        if (a == 9'd2) return {29'b0, m_stat};
        if (a == 9'd3) return {29'b0, m_en};
        if (a == 9'd4) return FIFO_EN ? {14'b0, sz == DEPTH, sz == 0, 16'(sz)} : 32'h0;
        if (a == 9'd5) return (FIFO_EN && sz > 0) ? m_q[0] : 32'h0;
        if (a >= 9'd16 && a < 9'(16 + NRW)) return m_rw[a - 9'd16];
        return 32'h0;
    endfunction

    task automatic idle();
        wr_addr = 9'd0; wdata = 32'h0; wstrb = 4'b0; rd_addr = 9'd0;
        rd_strobe = 1'b0; fifo_v = 1'b0; fifo_d = 32'h0; irq_ev = 1'b0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_addr = a; wdata = d; wstrb = s;
        cycle();
        wstrb = 4'b0;
    endtask

    task automatic test_reset();
        logic [8:0]  addrs [3];
        logic [31:0] exps [3];
        idle();
        rst = 1'b1;
        #23;
        model_reset();
        rst = 1'b0;
        cycle();
        addrs = '{9'd0, 9'd4, 9'd16};
        exps  = '{32'hCA0B_0001, (FIFO_EN ? 32'h0001_0000 : 32'h0), 32'h0};
        for (int i = 0; i < 3; i++) begin
            rd_addr = addrs[i];
            #1;
            n_checks++;
            if (rdata !== exps[i]) begin
                n_fail++; $display("FAIL reset_read[%0h]: got %h expected %h", addrs[i], rdata, exps[i]);
            end
        end
        n_checks++;
        if ({irq, sw_reset} !== 2'b00) begin
            n_fail++; $display("FAIL reset_outputs: got irq=%b swr=%b expected 0 0", irq, sw_reset);
        end
    endtask

    task automatic test_byte_strobe();
        do_write(9'd16, 32'h1122_3344, 4'hF);
        do_write(9'd16, 32'hDEAD_BEEF, 4'b0101);
        n_checks++;
        if (rw_regs[31:0] !== 32'h11AD_33EF) begin
            n_fail++; $display("FAIL byte_strobe: got %h expected %h", rw_regs[31:0], 32'h11AD_33EF);
        end
        do_write(9'd23, 32'hA5A5_5A5A, 4'b1000);
        rd_addr = 9'd23;
        #1;
        n_checks++;
        if (rdata !== 32'hA500_0000 || rw_regs[7*32 +: 32] !== 32'hA500_0000) begin
            n_fail++; $display("FAIL reg7_lane3: got rd=%h out=%h expected a5000000", rdata, rw_regs[7*32 +: 32]);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] words [17];
        logic [31:0] e;
        do_write(9'd3, 32'h1, 4'h1);
        for (int i = 0; i < 17; i++) begin
            words[i] = $urandom;
            fifo_v = 1'b1; fifo_d = words[i];
            cycle();
        end
        fifo_v = 1'b0;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL ovf_irq_lag: got %b expected 0", irq);
        end
        cycle();
        n_checks++;
        if (irq !== FIFO_EN) begin
            n_fail++; $display("FAIL ovf_irq: got %b expected %b", irq, FIFO_EN);
        end
        rd_addr = 9'd4;
        #1;
        e = FIFO_EN ? 32'h0002_0010 : 32'h0;
        n_checks++;
        if (rdata !== e) begin
            n_fail++; $display("FAIL ovf_level: got %h expected %h", rdata, e);
        end
        rd_addr = 9'd2;
        #1;
        n_checks++;
        if (rdata !== {31'b0, FIFO_EN}) begin
            n_fail++; $display("FAIL ovf_flag: got %h expected %h", rdata, {31'b0, FIFO_EN});
        end
        for (int i = 0; i < 17; i++) begin
            rd_addr = 9'd5; rd_strobe = 1'b1;
            #1;
            e = (FIFO_EN && i < 16) ? words[i] : 32'h0;
            n_checks++;
            if (rdata !== e) begin
                n_fail++; $display("FAIL drain[%0d]: got %h expected %h", i, rdata, e);
            end
            cycle();
        end
        rd_strobe = 1'b0;
        rd_addr = 9'd2;
        #1;
        n_checks++;
        if (rdata !== {29'b0, FIFO_EN, 1'b0, FIFO_EN}) begin
            n_fail++; $display("FAIL udf_flag: got %h expected %h", rdata, {29'b0, FIFO_EN, 1'b0, FIFO_EN});
        end
        do_write(9'd2, 32'h7, 4'h1);
    endtask

    task automatic test_full_push_pop();
        logic [31:0] nw, e;
        for (int i = 0; i < DEPTH; i++) begin
            fifo_v = 1'b1; fifo_d = $urandom;
            cycle();
        end
        nw = $urandom;
        fifo_d = nw; rd_addr = 9'd5; rd_strobe = 1'b1;
        #1;
        e = exp_rdata(9'd5);
        n_checks++;
        if (rdata !== e) begin
            n_fail++; $display("FAIL full_head: got %h expected %h", rdata, e);
        end
        cycle();
        fifo_v = 1'b0; rd_strobe = 1'b0;
        rd_addr = 9'd4;
        #1;
        e = FIFO_EN ? 32'h0002_0010 : 32'h0;
        n_checks++;
        if (rdata !== e) begin
            n_fail++; $display("FAIL full_pushpop_level: got %h expected %h", rdata, e);
        end
        rd_addr = 9'd2;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL full_pushpop_ovf: got %h expected 0", rdata);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = 9'd5; rd_strobe = 1'b1;
            #1;
            e = (i == DEPTH - 1) ? (FIFO_EN ? nw : 32'h0) : exp_rdata(9'd5);
            n_checks++;
            if (rdata !== e) begin
                n_fail++; $display("FAIL full_drain[%0d]: got %h expected %h", i, rdata, e);
            end
            cycle();
        end
        rd_strobe = 1'b0;
    endtask

    task automatic test_irq_event();
        do_write(9'd3, 32'h7, 4'h1);
        irq_ev = 1'b1;
        do_write(9'd2, 32'h2, 4'h1);
        irq_ev = 1'b0;
        rd_addr = 9'd2;
        #1;
        n_checks++;
        if (rdata !== 32'h2) begin
            n_fail++; $display("FAIL set_beats_clear: got %h expected 2", rdata);
        end
        cycle();
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL event_irq: got %b expected 1", irq);
        end
        do_write(9'd2, 32'h2, 4'h1);
        #1;
        n_checks++;
        if (rdata !== 32'h0 || irq !== 1'b1) begin
            n_fail++; $display("FAIL w1c: got stat=%h irq=%b expected 0 1", rdata, irq);
        end
        cycle();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_fall: got %b expected 0", irq);
        end
    endtask

    task automatic test_flush();
        logic [31:0] e;
        for (int i = 0; i < 5; i++) begin
            fifo_v = 1'b1; fifo_d = $urandom;
            cycle();
        end
        fifo_d = $urandom;
        do_write(9'd1, 32'h3, 4'hF);
        fifo_v = 1'b0;
        n_checks++;
        if (sw_reset !== 1'b1) begin
            n_fail++; $display("FAIL swr_pulse: got %b expected 1", sw_reset);
        end
        rd_addr = 9'd4;
        #1;
        e = FIFO_EN ? 32'h0001_0000 : 32'h0;
        n_checks++;
        if (rdata !== e) begin
            n_fail++; $display("FAIL flush_level: got %h expected %h", rdata, e);
        end
        rd_addr = 9'd2;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL flush_ovf: got %h expected 0", rdata);
        end
        cycle();
        n_checks++;
        if (sw_reset !== 1'b0 || rw_regs[31:0] !== 32'h11AD_33EF) begin
            n_fail++; $display("FAIL swr_end: got swr=%b reg0=%h expected 0 11ad33ef", sw_reset, rw_regs[31:0]);
        end
    endtask

    task automatic test_random();
        logic [31:0]       e;
        logic [NRW*32-1:0] erw;
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(0, 2) == 0) begin
                wr_addr = 9'($urandom_range(0, 24));
                wdata = $urandom;
                wstrb = 4'($urandom_range(1, 15));
            end
            rd_addr = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(4, 5)) : 9'($urandom_range(0, 24));
            rd_strobe = ($urandom_range(0, 2) == 0);
            fifo_v = ($urandom_range(0, 1) == 0);
            fifo_d = $urandom;
            irq_ev = ($urandom_range(0, 7) == 0);
            #1;
            e = exp_rdata(rd_addr);
            n_checks++;
            if (rdata !== e) begin
                n_fail++; $display("FAIL rnd_rdata[%0d] @%0h: got %h expected %h", c, rd_addr, rdata, e);
            end
            cycle();
            for (int i = 0; i < NRW; i++) erw[i*32 +: 32] = m_rw[i];
            n_checks++;
            if (irq !== m_irq || sw_reset !== m_swr || rw_regs !== erw) begin
                n_fail++; $display("FAIL rnd_outputs[%0d]: got irq=%b swr=%b expected %b %b (regs match=%b)",
                                   c, irq, sw_reset, m_irq, m_swr, rw_regs === erw);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            fifo_v = 1'b1; fifo_d = $urandom;
            cycle();
        end
        fifo_v = 1'b0;
        irq_ev = 1'b1;
        do_write(9'd17, 32'hFFFF_FFFF, 4'hF);
        irq_ev = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        rd_addr = 9'd4;
        #1;
        n_checks++;
        if (rdata !== (FIFO_EN ? 32'h0001_0000 : 32'h0) || rw_regs !== '0) begin
            n_fail++; $display("FAIL async_reset: got fstat=%h regs_zero=%b", rdata, rw_regs === '0);
        end
        rd_addr = 9'd2;
        #1;
        n_checks++;
        if (rdata !== 32'h0 || irq !== 1'b0 || sw_reset !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_flags: got stat=%h irq=%b swr=%b expected 0", rdata, irq, sw_reset);
        end
        #10;
        rst = 1'b0;
        rd_addr = 9'd0;
        cycle();
        n_checks++;
        if (rdata !== ID) begin
            n_fail++; $display("FAIL id_after_reset: got %h expected %h", rdata, ID);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        test_reset();
        test_byte_strobe();
        test_fifo_overflow();
        test_full_push_pop();
        test_irq_event();
        test_flush();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
